// File: rtl/pwm_capture_packer_pkg.sv
// Shared constants for the PWM capture packer: FSM states, packet type code,
// packet field widths and configuration bit positions.
package pwm_capture_packer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_HIGH = 3'd2,
    ST_LOW  = 3'd3,
    ST_DONE = 3'd4
  } cap_state_e;

  localparam logic [2:0] PKT_PWM_CAP    = 3'b101;
  localparam int         PKT_TYPE_WIDTH = 3;
  localparam int         PKT_ID_WIDTH   = 8;

  localparam int CFG_ENABLE_BIT      = 0;
  localparam int CFG_OVF_CLEAR_BIT   = 1;
  localparam int CFG_SINGLE_SHOT_BIT = 2;
  localparam int CFG_ID_LSB          = 8;

endpackage

// File: rtl/pwm_capture_packer_sync_edge.sv
// Two-flop synchronizer for the external PWM input followed by a level flop;
// rise/fall are registered pulses aligned with the level change.
module pwm_in_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic level_q, level_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Next-state of the synchronizer chain and edge pulses
  always_comb begin
    meta_d  = async_in;
    sync_d  = meta_q;
    level_d = sync_q;
    rise_d  = sync_q & ~level_q;
    fall_d  = ~sync_q & level_q;
  end

  // Synchronizer and edge-detect registers
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/pwm_capture_packer.sv
// Measures period and high time of an external PWM input in clk1 cycles and
// hands each result to the host path through a single-entry packet register.
module pwm_capture_packer
  import pwm_capture_packer_pkg::*;
#(
  parameter int DATA_PACKET_WIDTH = 51,
  parameter int CONFIG_DATA_WIDTH = 32,
  parameter int CNT_WIDTH         = 20
) (
  input  logic                         clk1,
  input  logic                         rst,
  input  logic [CONFIG_DATA_WIDTH-1:0] pwm_config_data,
  input  logic                         pwm_in,
  input  logic                         rd_ready,
  output logic                         dt_pwm_fifo_enable,
  output logic [DATA_PACKET_WIDTH-1:0] dt_pwm_fifo_data,
  output logic                         capture_ovf
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam int HIGH_LSB   = 0;
  localparam int PERIOD_LSB = CNT_WIDTH;
  localparam int ID_LSB     = 2 * CNT_WIDTH;
  localparam int TYPE_LSB   = 2 * CNT_WIDTH + PKT_ID_WIDTH;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  logic                    cfg_enable_s, cfg_ovf_clear_s, cfg_single_shot_s;
  logic [PKT_ID_WIDTH-1:0] cfg_id_s;
  logic                    cfg_unused_s;
  logic                    sync_level_s, sync_rise_s, sync_fall_s;
  logic                    emit_s, drop_s;
  logic [DATA_PACKET_WIDTH-1:0] pkt_s;

  cap_state_e                   state_q, state_d;
  logic [CNT_WIDTH-1:0]         period_q, period_d;
  logic [CNT_WIDTH-1:0]         high_q, high_d;
  logic                         pkt_valid_q, pkt_valid_d;
  logic [DATA_PACKET_WIDTH-1:0] pkt_data_q, pkt_data_d;
  logic                         ovf_q, ovf_d;

  assign cfg_enable_s      = pwm_config_data[CFG_ENABLE_BIT];
  assign cfg_ovf_clear_s   = pwm_config_data[CFG_OVF_CLEAR_BIT];
  assign cfg_single_shot_s = pwm_config_data[CFG_SINGLE_SHOT_BIT];
  assign cfg_id_s          = pwm_config_data[CFG_ID_LSB +: PKT_ID_WIDTH];
  assign cfg_unused_s      = ^{pwm_config_data[CONFIG_DATA_WIDTH-1:CFG_ID_LSB+PKT_ID_WIDTH],
                               pwm_config_data[CFG_ID_LSB-1:CFG_SINGLE_SHOT_BIT+1]};

  pwm_in_sync_edge u_sync (
    .clk      (clk1),
    .rst      (rst),
    .async_in (pwm_in),
    .level    (sync_level_s),
    .rise     (sync_rise_s),
    .fall     (sync_fall_s)
  );

  // Packet image of the current counters; unused upper bits stay zero
  always_comb begin
    pkt_s                              = '0;
    pkt_s[HIGH_LSB +: CNT_WIDTH]       = high_q;
    pkt_s[PERIOD_LSB +: CNT_WIDTH]     = period_q;
    pkt_s[ID_LSB +: PKT_ID_WIDTH]      = cfg_id_s;
    pkt_s[TYPE_LSB +: PKT_TYPE_WIDTH]  = PKT_PWM_CAP;
  end

  // Measurement FSM: counters include the current cycle, so a rise restarts at 1
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    high_d   = high_q;
    emit_s   = 1'b0;
    if (!cfg_enable_s) begin
      state_d  = ST_IDLE;
      period_d = '0;
      high_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_ARM;
          period_d = '0;
          high_d   = '0;
        end
        ST_ARM: begin
          if (sync_rise_s) begin
            state_d  = ST_HIGH;
            period_d = CNT_ONE;
            high_d   = CNT_ONE;
          end else begin
            state_d  = ST_ARM;
          end
        end
        ST_HIGH: begin
          if (period_q == CNT_MAX) begin
            emit_s   = 1'b1;
            state_d  = ST_ARM;
            period_d = '0;
            high_d   = '0;
          end else begin
            period_d = sat_inc(period_q);
            high_d   = sync_level_s ? sat_inc(high_q) : high_q;
            state_d  = sync_fall_s ? ST_LOW : ST_HIGH;
          end
        end
        ST_LOW: begin
          if (sync_rise_s) begin
            emit_s   = 1'b1;
            period_d = CNT_ONE;
            high_d   = CNT_ONE;
            state_d  = cfg_single_shot_s ? ST_DONE : ST_HIGH;
          end else if (period_q == CNT_MAX) begin
            emit_s   = 1'b1;
            state_d  = ST_ARM;
            period_d = '0;
            high_d   = '0;
          end else begin
            period_d = sat_inc(period_q);
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d  = ST_IDLE;
          period_d = '0;
          high_d   = '0;
        end
      endcase
    end
  end

  // Single-entry output buffer; a drain and a new emit in one cycle keep valid high
  always_comb begin
    pkt_valid_d = pkt_valid_q;
    pkt_data_d  = pkt_data_q;
    drop_s      = 1'b0;
    if (pkt_valid_q && rd_ready) begin
      if (emit_s) begin
        pkt_data_d  = pkt_s;
        pkt_valid_d = 1'b1;
      end else begin
        pkt_valid_d = 1'b0;
      end
    end else if (pkt_valid_q) begin
      if (emit_s) begin
        drop_s = 1'b1;
      end else begin
        drop_s = 1'b0;
      end
    end else begin
      if (emit_s) begin
        pkt_data_d  = pkt_s;
        pkt_valid_d = 1'b1;
      end else begin
        pkt_valid_d = 1'b0;
      end
    end
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (cfg_ovf_clear_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State, counter, packet and overflow registers
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      period_q    <= '0;
      high_q      <= '0;
      pkt_valid_q <= 1'b0;
      pkt_data_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      high_q      <= high_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_data_q  <= pkt_data_d;
      ovf_q       <= ovf_d;
    end
  end

  assign dt_pwm_fifo_enable = pkt_valid_q;
  assign dt_pwm_fifo_data   = pkt_data_q;
  assign capture_ovf        = ovf_q;

endmodule

// File: tb/tb_pwm_capture_packer.sv
// Scoreboard bench: directed PWM waveforms push expected packets into queues,
// per-DUT monitors compare every presented packet against the queue head.
module tb_pwm_capture_packer;

  localparam logic [7:0] ID1 = 8'hA5;
  localparam logic [7:0] ID2 = 8'h3C;

  logic        clk1 = 1'b0;
  logic        rst;
  logic [31:0] cfg, cfg2;
  logic        pwm, pwm2;
  logic        rd_ready, rd_ready2;
  logic        en1, en2, ovf1, ovf2;
  logic [50:0] data1;
  logic [26:0] data2;

  int errors = 0;
  int checks = 0;
  logic [50:0] q1[$];
  logic [26:0] q2[$];
  logic hold1 = 1'b0;
  logic hold2 = 1'b0;

  always #5 clk1 = ~clk1;

  pwm_capture_packer dut (
    .clk1               (clk1),
    .rst                (rst),
    .pwm_config_data    (cfg),
    .pwm_in             (pwm),
    .rd_ready           (rd_ready),
    .dt_pwm_fifo_enable (en1),
    .dt_pwm_fifo_data   (data1),
    .capture_ovf        (ovf1)
  );

  pwm_capture_packer #(.DATA_PACKET_WIDTH(27), .CONFIG_DATA_WIDTH(32), .CNT_WIDTH(8)) dut8 (
    .clk1               (clk1),
    .rst                (rst),
    .pwm_config_data    (cfg2),
    .pwm_in             (pwm2),
    .rd_ready           (rd_ready2),
    .dt_pwm_fifo_enable (en2),
    .dt_pwm_fifo_data   (data2),
    .capture_ovf        (ovf2)
  );

  function automatic logic [50:0] pkt1(input logic [19:0] p, input logic [19:0] h);
    return {3'b101, ID1, p, h};
  endfunction

  function automatic logic [26:0] pkt2(input logic [7:0] p, input logic [7:0] h);
    return {3'b101, ID2, p, h};
  endfunction

  function automatic logic [31:0] cfg_word(input logic en, input logic clr, input logic ss,
                                           input logic [7:0] id);
    return {16'h0000, id, 5'b00000, ss, clr, en};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk1);
    #1;
  endtask

  // One PWM period (hi cycles high, lo cycles low) starting after the next posedge
  task automatic pwm_period(input int sel, input int hi, input int lo);
    for (int c = 0; c < hi + lo; c++) begin
      @(posedge clk1);
      #2;
      if (sel == 1) pwm = (c < hi);
      else pwm2 = (c < hi);
    end
  endtask

  // Monitor for the 20-bit instance
  always @(negedge clk1) begin
    if (rst) begin
      hold1 = 1'b0;
    end else begin
      if (hold1) check("hold_enable1", en1, 1'b1);
      if (en1) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pkt1: got %0h expected none at %0t", data1, $time);
        end else begin
          check("pkt1", data1, q1[0]);
          if (rd_ready) void'(q1.pop_front());
        end
      end
      hold1 = en1 && !rd_ready;
    end
  end

  // Monitor for the 8-bit instance
  always @(negedge clk1) begin
    if (rst) begin
      hold2 = 1'b0;
    end else begin
      if (hold2) check("hold_enable2", en2, 1'b1);
      if (en2) begin
        if (q2.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pkt2: got %0h expected none at %0t", data2, $time);
        end else begin
          check("pkt2", data2, q2[0]);
          if (rd_ready2) void'(q2.pop_front());
        end
      end
      hold2 = en2 && !rd_ready2;
    end
  end

  initial begin
    rst = 1'b1; cfg = 32'h0; cfg2 = 32'h0; pwm = 1'b0; pwm2 = 1'b0;
    rd_ready = 1'b0; rd_ready2 = 1'b1;
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    check("reset_en1", en1, 1'b0);
    check("reset_data1", data1, 51'h0);
    check("reset_ovf1", ovf1, 1'b0);
    check("reset_en2", en2, 1'b0);
    check("reset_data2", data2, 27'h0);
    @(posedge clk1); #1 rst = 1'b0;

    // Continuous mode: 5 rises -> 4 packets of {10,4}
    rd_ready = 1'b1;
    cfg = cfg_word(1'b1, 1'b0, 1'b0, ID1);
    wait_cycles(3);
    repeat (4) q1.push_back(pkt1(20'd10, 20'd4));
    repeat (5) pwm_period(1, 4, 6);
    wait_cycles(8);
    cfg = 32'h0;
    wait_cycles(3);

    // Consumer stalled: first packet held, later ones dropped, ovf sticky then cleared
    rd_ready = 1'b0;
    cfg = cfg_word(1'b1, 1'b0, 1'b0, ID1);
    wait_cycles(3);
    q1.push_back(pkt1(20'd10, 20'd4));
    repeat (4) pwm_period(1, 4, 6);
    wait_cycles(4);
    @(negedge clk1);
    check("ovf_set", ovf1, 1'b1);
    check("held_enable", en1, 1'b1);
    @(posedge clk1); #1 cfg = cfg_word(1'b1, 1'b1, 1'b0, ID1);
    @(posedge clk1); #1 cfg = cfg_word(1'b1, 1'b0, 1'b0, ID1);
    @(negedge clk1);
    check("ovf_clear", ovf1, 1'b0);
    @(posedge clk1); #1 rd_ready = 1'b1;
    wait_cycles(3);
    rd_ready = 1'b0;
    cfg = 32'h0;
    wait_cycles(3);

    // Drain and emit in the same cycle
    cfg = cfg_word(1'b1, 1'b0, 1'b0, ID1);
    wait_cycles(3);
    q1.push_back(pkt1(20'd8, 20'd3));
    q1.push_back(pkt1(20'd12, 20'd5));
    pwm_period(1, 3, 5);
    pwm_period(1, 5, 7);
    fork
      pwm_period(1, 2, 6);
      begin
        repeat (4) @(posedge clk1);
        #1 rd_ready = 1'b1;
        @(posedge clk1);
        #1 rd_ready = 1'b0;
        @(negedge clk1);
        check("drain_emit_enable", en1, 1'b1);
        check("drain_emit_data", data1, pkt1(20'd12, 20'd5));
        check("drain_emit_ovf", ovf1, 1'b0);
      end
    join
    wait_cycles(2);
    rd_ready = 1'b1;
    wait_cycles(3);
    rd_ready = 1'b0;
    cfg = 32'h0;
    wait_cycles(3);

    // Single-shot: one packet per enable
    rd_ready = 1'b1;
    cfg = cfg_word(1'b1, 1'b0, 1'b1, ID1);
    wait_cycles(3);
    q1.push_back(pkt1(20'd10, 20'd4));
    repeat (3) pwm_period(1, 4, 6);
    wait_cycles(5);
    cfg = cfg_word(1'b0, 1'b0, 1'b1, ID1);
    wait_cycles(3);
    cfg = cfg_word(1'b1, 1'b0, 1'b1, ID1);
    wait_cycles(3);
    q1.push_back(pkt1(20'd10, 20'd4));
    repeat (3) pwm_period(1, 4, 6);
    wait_cycles(5);
    cfg = 32'h0;
    wait_cycles(3);

    // Reset mid-HIGH with a pending packet and ovf set
    rd_ready = 1'b0;
    cfg = cfg_word(1'b1, 1'b0, 1'b0, ID1);
    wait_cycles(3);
    q1.push_back(pkt1(20'd10, 20'd4));
    repeat (3) pwm_period(1, 4, 6);
    wait_cycles(2);
    @(negedge clk1);
    check("ovf_before_rst", ovf1, 1'b1);
    fork
      pwm_period(1, 4, 6);
      begin
        repeat (6) @(posedge clk1);
        #1 rst = 1'b1;
        @(posedge clk1);
        #1 rst = 1'b0;
        @(negedge clk1);
        check("rst_en1", en1, 1'b0);
        check("rst_data1", data1, 51'h0);
        check("rst_ovf1", ovf1, 1'b0);
        q1.delete();
      end
    join
    rd_ready = 1'b1;
    q1.push_back(pkt1(20'd10, 20'd4));
    repeat (2) pwm_period(1, 4, 6);
    wait_cycles(6);
    cfg = 32'h0;
    wait_cycles(3);

    // Saturation on the 8-bit instance: stuck high -> {255,255}, then back to ARM
    cfg2 = cfg_word(1'b1, 1'b0, 1'b0, ID2);
    wait_cycles(3);
    q2.push_back(pkt2(8'd255, 8'd255));
    q2.push_back(pkt2(8'd10, 8'd4));
    @(posedge clk1); #2 pwm2 = 1'b1;
    wait_cycles(300);
    @(posedge clk1); #2 pwm2 = 1'b0;
    wait_cycles(10);
    repeat (2) pwm_period(2, 4, 6);
    wait_cycles(6);
    cfg2 = 32'h0;
    wait_cycles(3);

    check("q1_drained", q1.size(), 0);
    check("q2_drained", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
